// File: rtl/text_pkg.sv
// text_pkg: shared definitions for the text path (write controller,
// character RAM and renderer).
//   - ASCII control/printable constants
//   - state_t : write-controller FSM states
//   - char_class_t : class of a received byte
//   - is_printable() : printable-range test for an 8-bit code
package text_pkg;

  localparam logic [7:0] ASCII_BS       = 8'h08;
  localparam logic [7:0] ASCII_LF       = 8'h0A;
  localparam logic [7:0] ASCII_CR       = 8'h0D;
  localparam logic [7:0] ASCII_ESC      = 8'h1B;
  localparam logic [7:0] ASCII_PRINT_LO = 8'h20;
  localparam logic [7:0] ASCII_PRINT_HI = 8'h7E;

  typedef enum logic {
    IDLE,
    CLEAR_WAIT
  } state_t;

  typedef enum logic [2:0] {
    CLS_PRINT,
    CLS_CR,
    CLS_LF,
    CLS_BS,
    CLS_ESC,
    CLS_OTHER
  } char_class_t;

  function automatic logic is_printable(input logic [7:0] code);
    return (code >= ASCII_PRINT_LO) && (code <= ASCII_PRINT_HI);
  endfunction

endpackage

// File: rtl/text_char_class.sv
// text_char_class: purely combinational byte classifier.
// Ports:
//   rx_data  in   DATA_WIDTH  received byte
//   cls      out  char_class_t  PRINT / CR / LF / BS / ESC / OTHER
// Bytes wider than 8 bits with any upper bit set are classed OTHER.
module text_char_class
  import text_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] rx_data,
  output char_class_t           cls
);

  logic is_ascii;
  logic [7:0] code;

  always_comb begin
    code     = rx_data[7:0];
    is_ascii = (rx_data >> 8) == '0;
    cls      = CLS_OTHER;
    if (is_ascii) begin
      if (is_printable(code))   cls = CLS_PRINT;
      else if (code == ASCII_CR)  cls = CLS_CR;
      else if (code == ASCII_LF)  cls = CLS_LF;
      else if (code == ASCII_BS)  cls = CLS_BS;
      else if (code == ASCII_ESC) cls = CLS_ESC;
    end
  end

endmodule

// File: rtl/text_write_ctrl.sv
// text_write_ctrl: turns received ASCII bytes into character-RAM writes,
// owns the text cursor and issues whole-screen clear requests.
// Ports:
//   clk, reset (async, active-high)
//   rx_data/rx_valid/rx_ready : byte input handshake
//   we, w_row, w_col, din     : RAM write port (address/data hold when we=0)
//   clear                     : one-cycle RAM wipe request
//   cur_row, cur_col          : current cursor
// Build option: define TEXT_WR_BACKSPACE_EN to handle 0x08 as an erasing
// backspace; otherwise 0x08 is consumed with no effect.
// All outputs are registered; the byte accepted on an edge produces its
// write/clear in the following cycle and moves the cursor on that edge.
module text_write_ctrl
  import text_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int ROWS         = 4,
  parameter int COLS         = 32,
  parameter int CLEAR_CYCLES = ROWS*COLS+2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DATA_WIDTH-1:0]     rx_data,
  input  logic                      rx_valid,
  output logic                      rx_ready,
  output logic                      we,
  output logic [$clog2(ROWS)-1:0]   w_row,
  output logic [$clog2(COLS)-1:0]   w_col,
  output logic [DATA_WIDTH-1:0]     din,
  output logic                      clear,
  output logic [$clog2(ROWS)-1:0]   cur_row,
  output logic [$clog2(COLS)-1:0]   cur_col
);

  localparam int ROW_W = $clog2(ROWS);
  localparam int COL_W = $clog2(COLS);
  localparam int CNT_W = (CLEAR_CYCLES > 2) ? $clog2(CLEAR_CYCLES) : 1;

  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS-1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS-1);

  char_class_t cls;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [ROW_W-1:0]       row_d, row_inc;
  logic [COL_W-1:0]       col_d;
  logic                   we_d, clear_d;
  logic [ROW_W-1:0]       w_row_d;
  logic [COL_W-1:0]       w_col_d;
  logic [DATA_WIDTH-1:0]  din_d;

  text_char_class #(.DATA_WIDTH(DATA_WIDTH)) u_class (
    .rx_data (rx_data),
    .cls     (cls)
  );

  // Explicit wrap compare keeps non-power-of-two ROWS correct.
  assign row_inc = (cur_row == ROW_LAST) ? '0 : cur_row + ROW_W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    row_d   = cur_row;
    col_d   = cur_col;
    we_d    = 1'b0;
    clear_d = 1'b0;
    w_row_d = w_row;
    w_col_d = w_col;
    din_d   = din;

    unique case (state_q)
      IDLE: begin
        if (rx_valid) begin
          case (cls)
            CLS_PRINT: begin
              we_d    = 1'b1;
              w_row_d = cur_row;
              w_col_d = cur_col;
              din_d   = rx_data;
              if (cur_col == COL_LAST) begin
                col_d = '0;
                row_d = row_inc;
              end else begin
                col_d = cur_col + COL_W'(1);
              end
            end
            CLS_CR: col_d = '0;
            CLS_LF: begin
              col_d = '0;
              row_d = row_inc;
            end
`ifdef TEXT_WR_BACKSPACE_EN
            CLS_BS: begin
              // Erase the cell the cursor steps back onto; (0,0) is a no-op.
              if (cur_col != '0) begin
                col_d   = cur_col - COL_W'(1);
                we_d    = 1'b1;
                w_row_d = cur_row;
                w_col_d = cur_col - COL_W'(1);
                din_d   = '0;
              end else if (cur_row != '0) begin
                row_d   = cur_row - ROW_W'(1);
                col_d   = COL_LAST;
                we_d    = 1'b1;
                w_row_d = cur_row - ROW_W'(1);
                w_col_d = COL_LAST;
                din_d   = '0;
              end
            end
`endif
            CLS_ESC: begin
              clear_d = 1'b1;
              row_d   = '0;
              col_d   = '0;
              state_d = CLEAR_WAIT;
              cnt_d   = CNT_W'(CLEAR_CYCLES-1);
            end
            default: ;
          endcase
        end
      end
      CLEAR_WAIT: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rx_ready <= 1'b1;
      we       <= 1'b0;
      clear    <= 1'b0;
      w_row    <= '0;
      w_col    <= '0;
      din      <= '0;
      cur_row  <= '0;
      cur_col  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rx_ready <= (state_d == IDLE);
      we       <= we_d;
      clear    <= clear_d;
      w_row    <= w_row_d;
      w_col    <= w_col_d;
      din      <= din_d;
      cur_row  <= row_d;
      cur_col  <= col_d;
    end
  end

endmodule

// File: tb/tb_text_write_ctrl.sv
// Self-checking bench for text_write_ctrl: directed scenarios with literal
// expectations followed by randomized traffic, all compared every cycle
// against a linear-cursor behavioural model.
module tb_text_write_ctrl;

  localparam int ROWS  = 4;
  localparam int COLS  = 32;
  localparam int NCELL = ROWS*COLS;
  localparam int CC    = NCELL + 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready, we, clear;
  logic [1:0] w_row, cur_row;
  logic [4:0] w_col, cur_col;
  logic [7:0] din;

  text_write_ctrl #(.DATA_WIDTH(8), .ROWS(ROWS), .COLS(COLS)) dut (
    .clk      (clk),
    .reset    (reset),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .we       (we),
    .w_row    (w_row),
    .w_col    (w_col),
    .din      (din),
    .clear    (clear),
    .cur_row  (cur_row),
    .cur_col  (cur_col)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model: cursor as a linear cell index, outputs as plain ints.
  int m_pos, m_low, m_wrow, m_wcol, m_din;
  bit m_ready, m_we, m_clear;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pos = 0; m_low = 0; m_ready = 1; m_we = 0; m_clear = 0;
    m_wrow = 0; m_wcol = 0; m_din = 0;
  endtask

  task automatic model_edge(input bit valid, input int data);
    int r, c;
    m_we = 0;
    m_clear = 0;
    if (!m_ready) begin
      m_low--;
      if (m_low == 0) m_ready = 1;
    end else if (valid) begin
      r = m_pos / COLS;
      c = m_pos % COLS;
      if (data >= 32'h20 && data <= 32'h7E) begin
        m_we = 1; m_wrow = r; m_wcol = c; m_din = data;
        m_pos = (m_pos + 1) % NCELL;
      end else if (data == 32'h0D) begin
        m_pos = r * COLS;
      end else if (data == 32'h0A) begin
        m_pos = ((r + 1) % ROWS) * COLS;
      end else if (data == 32'h1B) begin
        m_clear = 1; m_pos = 0; m_ready = 0; m_low = CC;
      end
`ifdef TEXT_WR_BACKSPACE_EN
      else if (data == 32'h08 && m_pos > 0) begin
        m_pos = m_pos - 1;
        m_we = 1; m_wrow = m_pos / COLS; m_wcol = m_pos % COLS; m_din = 0;
      end
`endif
    end
  endtask

  task automatic compare_all();
    chk("rx_ready", 32'(rx_ready), 32'(m_ready));
    chk("we",       32'(we),       32'(m_we));
    chk("clear",    32'(clear),    32'(m_clear));
    chk("cur_row",  32'(cur_row),  32'(m_pos / COLS));
    chk("cur_col",  32'(cur_col),  32'(m_pos % COLS));
    chk("w_row",    32'(w_row),    32'(m_wrow));
    chk("w_col",    32'(w_col),    32'(m_wcol));
    chk("din",      32'(din),      32'(m_din));
  endtask

  task automatic step(input bit valid, input logic [7:0] data);
    rx_valid = valid;
    rx_data  = data;
    @(posedge clk);
    model_edge(valid, int'(data));
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    reset    = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    compare_all();
    reset = 1'b0;
  endtask

  task automatic send_n(input int n, input logic [7:0] data);
    for (int i = 0; i < n; i++) step(1'b1, data);
  endtask

  initial begin
    int low_cycles;
    int r;
    logic [7:0] b;

    rx_valid = 1'b0;
    rx_data  = 8'h00;
    reset    = 1'b1;
    model_reset();
    #2;
    do_reset();
    chk("reset_ready_lit", 32'(rx_ready), 32'd1);
    chk("reset_we_lit",    32'(we),       32'd0);

    // 'A','B' back to back
    step(1'b1, 8'h41);
    chk("A_we_lit",  32'(we),    32'd1);
    chk("A_din_lit", 32'(din),   32'h41);
    chk("A_col_lit", 32'(w_col), 32'd0);
    step(1'b1, 8'h42);
    chk("B_din_lit", 32'(din),   32'h42);
    chk("B_col_lit", 32'(w_col), 32'd1);
    step(1'b0, 8'h00);
    chk("AB_cur_col_lit", 32'(cur_col), 32'd2);
    chk("AB_idle_we_lit", 32'(we),      32'd0);

    // Row wrap at end of line and screen wrap at (3,31)
    do_reset();
    send_n(31, 8'h78);
    step(1'b1, 8'h5A);
    chk("Z_wcol_lit",   32'(w_col),   32'd31);
    chk("Z_din_lit",    32'(din),     32'h5A);
    chk("Z_currow_lit", 32'(cur_row), 32'd1);
    chk("Z_curcol_lit", 32'(cur_col), 32'd0);
    send_n(95, 8'h79);
    step(1'b1, 8'h5A);
    chk("Z2_wrow_lit",  32'(w_row),   32'd3);
    chk("Z2_currow_lit",32'(cur_row), 32'd0);
    chk("Z2_curcol_lit",32'(cur_col), 32'd0);

    // LF at (2,5), CR at (1,7)
    do_reset();
    send_n(2, 8'h0A);
    send_n(5, 8'h61);
    step(1'b1, 8'h0A);
    chk("LF_we_lit",  32'(we),      32'd0);
    chk("LF_row_lit", 32'(cur_row), 32'd3);
    chk("LF_col_lit", 32'(cur_col), 32'd0);
    do_reset();
    step(1'b1, 8'h0A);
    send_n(7, 8'h62);
    step(1'b1, 8'h0D);
    chk("CR_we_lit",  32'(we),      32'd0);
    chk("CR_row_lit", 32'(cur_row), 32'd1);
    chk("CR_col_lit", 32'(cur_col), 32'd0);

    // Backspace at (1,0) and at (0,0)
    do_reset();
    step(1'b1, 8'h0A);
    step(1'b1, 8'h08);
`ifdef TEXT_WR_BACKSPACE_EN
    chk("BS_we_lit",   32'(we),      32'd1);
    chk("BS_wrow_lit", 32'(w_row),   32'd0);
    chk("BS_wcol_lit", 32'(w_col),   32'd31);
    chk("BS_din_lit",  32'(din),     32'd0);
    chk("BS_cur_lit",  32'(cur_col), 32'd31);
`else
    chk("BS_we_lit",   32'(we),      32'd0);
    chk("BS_row_lit",  32'(cur_row), 32'd1);
    chk("BS_col_lit",  32'(cur_col), 32'd0);
`endif
    do_reset();
    step(1'b1, 8'h08);
    chk("BS0_we_lit",  32'(we),      32'd0);
    chk("BS0_col_lit", 32'(cur_col), 32'd0);

    // ESC with valid held high: exact clear window, then write at (0,0)
    do_reset();
    step(1'b1, 8'h51);
    step(1'b1, 8'h1B);
    chk("ESC_clear_lit", 32'(clear),   32'd1);
    chk("ESC_ready_lit", 32'(rx_ready),32'd0);
    chk("ESC_col_lit",   32'(cur_col), 32'd0);
    low_cycles = 1;
    for (int i = 0; i < 300 && rx_ready == 1'b0; i++) begin
      step(1'b1, 8'h4B);
      if (rx_ready == 1'b0) low_cycles++;
    end
    chk("ESC_low_cycles_lit", 32'(low_cycles), 32'd130);
    step(1'b1, 8'h4B);
    chk("ESC_next_we_lit",  32'(we),    32'd1);
    chk("ESC_next_row_lit", 32'(w_row), 32'd0);
    chk("ESC_next_col_lit", 32'(w_col), 32'd0);
    chk("ESC_next_din_lit", 32'(din),   32'h4B);

    // Reset 10 cycles into the clear wait
    step(1'b1, 8'h1B);
    send_n(10, 8'h00);
    rx_valid = 1'b0;
    reset = 1'b1;
    #2;
    model_reset();
    chk("RST_async_ready", 32'(rx_ready), 32'd1);
    @(posedge clk);
    #1;
    compare_all();
    chk("RST_clear_lit", 32'(clear),   32'd0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(99);
      if (r < 55)      b = 8'(8'h20 + $urandom_range(94));
      else if (r < 65) b = 8'h0D;
      else if (r < 75) b = 8'h0A;
      else if (r < 87) b = 8'h08;
      else if (r < 89) b = 8'h1B;
      else             b = 8'($urandom_range(255));
      step($urandom_range(3) != 0, b);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/text_write_ctrl.md
# text_write_ctrl

Converts a stream of received ASCII bytes from the UART receiver into write transactions for the dual-port character RAM. It owns the text cursor (row, column) and issues data writes, cursor moves, backspace erases and whole-screen clear requests. It sits directly upstream of the character RAM write port.

## Interface
- DATA_WIDTH, 8, character width in bits
- ROWS, 4, text rows in the character RAM
- COLS, 32, text columns in the character RAM
- CLEAR_CYCLES, ROWS*COLS+2, cycles rx_ready stays low after a clear request; covers the RAM's one-cell-per-cycle wipe

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- rx_data  input  DATA_WIDTH  received byte
- rx_valid  input  1  rx_data valid this cycle
- rx_ready  output  1  byte accepted when rx_valid && rx_ready
- we  output  1  RAM write strobe, one cycle per write
- w_row  output  $clog2(ROWS)  RAM write row
- w_col  output  $clog2(COLS)  RAM write column
- din  output  DATA_WIDTH  RAM write data
- clear  output  1  one-cycle request to the RAM's reset input
- cur_row  output  $clog2(ROWS)  current cursor row
- cur_col  output  $clog2(COLS)  current cursor column

## Operation
- States: IDLE, CLEAR_WAIT. IDLE: rx_ready=1. CLEAR_WAIT: rx_ready=0, counter counts CLEAR_CYCLES-1 down to 0, then returns to IDLE.
- Byte classes on acceptance, all at cursor (r,c):
  - Printable 0x20–0x7E: write byte at (r,c). Cursor advances to c+1. At c=COLS-1 it goes to column 0, row r+1. At (ROWS-1, COLS-1) it wraps to (0,0).
  - 0x0D CR: cursor to (r,0); no write.
  - 0x0A LF: cursor to ((r+1) mod ROWS, 0); no write.
  - 0x08 BS: if c>0 the cursor moves to (r,c-1). If c=0 and r>0 it moves to (r-1,COLS-1). The new position is written with 0x00. At (0,0): no move, no write.
  - 0x1B ESC: pulse clear, cursor to (0,0), enter CLEAR_WAIT; no write.
  - Any other byte: consumed, no effect.
- Row/column arithmetic is modulo ROWS/COLS; the general case also supports non-power-of-two values.

## Timing
- Reset values: rx_ready=1, we=0, clear=0, w_row=w_col=0, din=0, cur_row=cur_col=0, state IDLE, counter 0.
- All outputs are registered. Accept on edge N → we/clear high for the cycle after edge N, with w_row/w_col/din valid in the same cycle. cur_row/cur_col update on edge N.
- Back-to-back bytes are accepted every cycle in IDLE. Each write uses the cursor value before that byte's update.
- w_row/w_col/din hold their last value when we=0.
- rx_ready drops the cycle after ESC is accepted and stays low for exactly CLEAR_CYCLES cycles.
- A reset asserted mid-CLEAR_WAIT aborts the wait immediately (IDLE, rx_ready=1) and does not re-issue clear.

## Configuration
- TEXT_WR_BACKSPACE_EN: defined → 0x08 handled as above. Undefined → 0x08 falls into "other byte" (consumed, no effect), and the backspace logic is not synthesised.

## Structure
- Shared package text_pkg: ASCII constants (ASCII_BS, ASCII_LF, ASCII_CR, ASCII_ESC, ASCII_PRINT_LO/HI) and the state enum type. The character RAM and renderer reuse these.
- One combinational sub-module, text_char_class: maps rx_data to the class {PRINT, CR, LF, BS, ESC, OTHER}.
- The cursor/next-cursor logic and the FSM live in text_write_ctrl.

## Test plan
- After reset, send 'A','B' on consecutive cycles → we pulses two cycles writing 0x41@(0,0) then 0x42@(0,1); cursor ends at (0,2).
- Cursor at (0,31), send 'Z' → write 0x5A@(0,31), cursor (1,0). At (3,31), send 'Z' → cursor (0,0).
- At (2,5), send LF → cursor (3,0), no we. Send CR at (1,7) → cursor (1,0), no we.
- With TEXT_WR_BACKSPACE_EN: BS at (1,0) → write 0x00@(0,31), cursor (0,31). BS at (0,0) → no we, cursor unchanged. Without the macro: BS → no we, cursor unchanged.
- Send ESC with rx_valid held high → clear one cycle, cursor (0,0), rx_ready low exactly 130 cycles (defaults), then the next byte writes at (0,0).
- Assert reset 10 cycles into CLEAR_WAIT → rx_ready=1 and every output at its reset value on the following edge, with no further clear pulse.
